alu_multicycle: RTL and testbench



---
 rtl/alu_multicycle.sv | 138 +++++++++++++
 tb/tb_alu_multicycle.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative 1-bit/cycle shifter
// with Start/Busy/Done handshake. Define ALU_FAST_SHIFT_EN for a barrel shifter.
module alu_multicycle #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero
);

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    state_t                 state, state_next;
    logic [DATA_WIDTH-1:0]  work, work_next;
    logic [DATA_WIDTH-1:0]  result, result_next;
    logic [SHAMT_WIDTH-1:0] cnt, cnt_next;
    logic [1:0]             sop, sop_next;
    logic                   done, done_next;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   is_shift;
    logic [DATA_WIDTH-1:0]  step;

    assign shamt    = SrcB[SHAMT_WIDTH-1:0];
    assign is_shift = (Operation == 4'b0101) || (Operation == 4'b0110) ||
                      (Operation == 4'b0111);

    // Without the barrel shifter, shift codes return SrcA: only the shamt=0
    // case ever takes this path, the rest go through the iterative shifter.
    function automatic logic [DATA_WIDTH-1:0] alu_op(
        input logic [3:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [SHAMT_WIDTH-1:0] s;
        s = b[SHAMT_WIDTH-1:0];
        case (op)
            4'b0000: alu_op = a & b;
            4'b0001: alu_op = a | b;
            4'b0010: alu_op = a + b;
            4'b0011: alu_op = a - b;
            4'b0100: alu_op = a ^ b;
`ifdef ALU_FAST_SHIFT_EN
            4'b0101: alu_op = a >> s;
            4'b0110: alu_op = a << s;
            4'b0111: alu_op = $signed(a) >>> s;
`else
            4'b0101, 4'b0110, 4'b0111: alu_op = (s == '0) ? a : '0;
`endif
            4'b1000: alu_op = {{(DATA_WIDTH-1){1'b0}}, (a == b)};
            4'b1100: alu_op = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_op = '0;
        endcase
    endfunction

    // sop holds Operation[1:0]: 01 SRL, 10 SLL, 11 SRA
    always_comb begin
        case (sop)
            2'b10:   step = {work[DATA_WIDTH-2:0], 1'b0};
            2'b11:   step = {work[DATA_WIDTH-1], work[DATA_WIDTH-1:1]};
            default: step = {1'b0, work[DATA_WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_next  = state;
        work_next   = work;
        cnt_next    = cnt;
        sop_next    = sop;
        result_next = result;
        done_next   = 1'b0;
        case (state)
            SHIFT: begin
                work_next = step;
                cnt_next  = cnt - 1'b1;
                if (cnt == {{(SHAMT_WIDTH-1){1'b0}}, 1'b1}) begin
                    result_next = step;
                    state_next  = IDLE;
                    done_next   = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                if (Start) begin
`ifdef ALU_FAST_SHIFT_EN
                    result_next = alu_op(Operation, SrcA, SrcB);
                    done_next   = 1'b1;
`else
                    if (is_shift && (shamt != '0)) begin
                        work_next  = SrcA;
                        cnt_next   = shamt;
                        sop_next   = Operation[1:0];
                        state_next = SHIFT;
                    end else begin
                        result_next = alu_op(Operation, SrcA, SrcB);
                        done_next   = 1'b1;
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            work   <= '0;
            cnt    <= '0;
            sop    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            work   <= work_next;
            cnt    <= cnt_next;
            sop    <= sop_next;
            result <= result_next;
            done   <= done_next;
        end
    end

`ifdef ALU_FAST_SHIFT_EN
    assign Busy = 1'b0;
`else
    assign Busy = (state == SHIFT);
`endif
    assign Done      = done;
    assign ALUResult = result;
    assign Zero      = (result == '0);

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: stimulus pushes expected result and
// completion cycle, a monitor pops on every Done and checks hold/Zero otherwise.
module tb_alu_multicycle;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         Start = 1'b0;
    logic [3:0]   Operation = '0;
    logic [W-1:0] SrcA = '0;
    logic [W-1:0] SrcB = '0;
    logic         Busy, Done, Zero;
    logic [W-1:0] ALUResult;

    alu_multicycle #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .Start(Start), .Operation(Operation),
        .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done),
        .ALUResult(ALUResult), .Zero(Zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        int           at;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] last_exp = '0;
    int           n_chk = 0;
    int           n_fail = 0;
    bit           mon_on = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference semantics straight from the operation table
    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        int s;
        s = int'(b[4:0]);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a - b;
            4'd4:  return a ^ b;
            4'd5:  return a >> s;
            4'd6:  return a << s;
            4'd7:  return W'($signed(a) >>> s);
            4'd8:  return (a == b) ? 1 : 0;
            4'd12: return ($signed(a) < $signed(b)) ? 1 : 0;
            default: return '0;
        endcase
    endfunction

    function automatic int extra_lat(input logic [3:0] op, input logic [W-1:0] b);
`ifdef ALU_FAST_SHIFT_EN
        return 0;
`else
        if (op >= 4'd5 && op <= 4'd7) return int'(b[4:0]);
        return 0;
`endif
    endfunction

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int k;
        exp_t e;
        k = 0;
        while (Busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (Busy) chk("busy_timeout", Busy, 1'b0);
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        Start     = 1'b1;
        e.res = model(op, a, b);
        e.at  = cyc + 1 + extra_lat(op, b);
        q.push_back(e);
        @(negedge clk);
        Start     = 1'b0;
        Operation = 4'($urandom);
        SrcA      = $urandom;
        SrcB      = $urandom;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) begin
                if (Done) begin
                    if (q.size() == 0) begin
                        chk("spurious_done", W'(Done), '0);
                    end else begin
                        e = q.pop_front();
                        chk("result", ALUResult, e.res);
                        chk("done_cycle", W'(cyc), W'(e.at));
                        chk("busy_in_done", W'(Busy), '0);
                        last_exp = e.res;
                    end
                end else begin
                    chk("result_hold", ALUResult, last_exp);
                end
                chk("zero", W'(Zero), W'(last_exp == '0));
            end
        end
    end

    logic [3:0] ops [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                             4'd8, 4'd12, 4'd9, 4'd15};

    initial begin : stim
        int k;
        logic [W-1:0] b;
        repeat (2) @(negedge clk);
        chk("rst_busy", W'(Busy), '0);
        chk("rst_done", W'(Done), '0);
        chk("rst_result", ALUResult, '0);
        chk("rst_zero", W'(Zero), 1);
        rst    = 1'b0;
        mon_on = 1'b1;

        issue(4'd2, 32'h5, 32'h3);
        issue(4'd3, 32'h5, 32'h5);
        issue(4'd12, 32'hFFFF_FFFF, 32'h1);
        issue(4'd8, 32'h1234, 32'h1234);

        issue(4'd7, 32'h8000_0000, 32'h4);
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_FAST_SHIFT_EN
            chk("sra_busy", W'(Busy), '0);
`else
            chk("sra_busy", W'(Busy), 1);
`endif
            @(negedge clk);
        end
        chk("sra_busy_after", W'(Busy), '0);

        issue(4'd6, 32'h1, 32'h20);
        issue(4'd6, 32'h1, 32'd31);

        // Start while busy must be dropped; Start in the Done cycle accepted
        issue(4'd5, 32'hDEAD_BEEF, 32'd8);
`ifndef ALU_FAST_SHIFT_EN
        Operation = 4'd4;
        SrcA      = 32'hFFFF_0000;
        SrcB      = 32'h0F0F_0F0F;
        Start     = 1'b1;
        @(negedge clk);
        Start = 1'b0;
`endif
        k = 0;
        while (!Done && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("srl_done_seen", W'(Done), 1);
        issue(4'd4, 32'hA5A5_0000, 32'h00FF_00FF);
        @(negedge clk);

        // Reset in the middle of a shift discards the op
        issue(4'd5, 32'hFFFF_FFFF, 32'd10);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        if (q.size() > 0) void'(q.pop_back());
        last_exp = '0;
        @(negedge clk);
        chk("mid_rst_busy", W'(Busy), '0);
        chk("mid_rst_done", W'(Done), '0);
        chk("mid_rst_result", ALUResult, '0);
        chk("mid_rst_zero", W'(Zero), 1);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 3);
            issue(ops[$urandom_range(0, 11)], $urandom, b);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        k = 0;
        while (q.size() > 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("queue_drained", W'(q.size()), '0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
